// File: rtl/regfile_sched_pkg.sv
// Shared types and constants for the SLC-3 register-file write-port scheduler.
package regfile_sched_pkg;

  localparam int NUM_REGS = 8;
  localparam int WORD_W   = 16;
  localparam int ADDR_W   = 3;

  typedef enum logic {
    CLEAR,
    RUN
  } sched_state_t;

  typedef struct packed {
    logic [ADDR_W-1:0] dr;
    logic [WORD_W-1:0] data;
  } wr_req_t;

  // Round-robin successor of a requester index, wrapping at n
  function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/regfile_wr_sched_rr_arbiter.sv
// rr_arbiter: NREQ-wide round-robin arbiter. The one-hot grant is combinational
// and the search starts at ptr; ptr moves just past the winner on every grant.
module rr_arbiter #(
  parameter int NREQ  = 3,
  parameter int PTR_W = $clog2(NREQ)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic [NREQ-1:0]  req,
  output logic [NREQ-1:0]  gnt,
  output logic [PTR_W-1:0] gnt_idx,
  output logic             gnt_valid
);
  import regfile_sched_pkg::*;

  logic [PTR_W-1:0] ptr;

  // Pick the first pending request at or above ptr, wrapping modulo NREQ
  always_comb begin
    int unsigned idx;
    logic [PTR_W-1:0] sel;
    gnt       = '0;
    gnt_idx   = '0;
    gnt_valid = 1'b0;
    idx       = 0;
    sel       = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx = 32'(ptr) + 32'(k);
      if (idx >= 32'(NREQ)) idx = idx - 32'(NREQ);
      sel = PTR_W'(idx);
      if (enable && !gnt_valid && req[sel]) begin
        gnt[sel]  = 1'b1;
        gnt_idx   = sel;
        gnt_valid = 1'b1;
      end
    end
  end

  // Advance the priority pointer past the winner; reset returns it to 0
  always_ff @(posedge clk) begin
    if (!reset) begin
      ptr <= '0;
    end else if (gnt_valid) begin
      ptr <= PTR_W'(rr_next(32'(gnt_idx), 32'(NREQ)));
    end
  end

endmodule

// File: rtl/regfile_wr_sched.sv
// regfile_wr_sched: shares the single register-file write port between NREQ
// requesters using round-robin arbitration, with registered write outputs.
// Optional feature macro REGFILE_CLEAR_EN: after every reset, sweep R0..R7 to
// zero (busy=1) before any request is served.
module regfile_wr_sched #(
  parameter int NREQ   = 3,
  parameter int WORD_W = 16,
  parameter int ADDR_W = 3,
  parameter int PTR_W  = $clog2(NREQ)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NREQ-1:0]          req,
  input  logic [NREQ*ADDR_W-1:0]   req_dr,
  input  logic [NREQ*WORD_W-1:0]   req_data,
  input  logic                     hold,
  output logic [NREQ-1:0]          gnt,
  output logic [ADDR_W-1:0]        wr_dr,
  output logic [WORD_W-1:0]        wr_data,
  output logic                     ld_reg,
  output logic                     busy
);
  import regfile_sched_pkg::*;

  sched_state_t     state_q;
  sched_state_t     state_d;
  logic             run_en;
  logic [PTR_W-1:0] gnt_idx;
  logic             gnt_valid;
  logic             sweep_wr;
  logic [ADDR_W-1:0] sweep_dr;

  // Grants are only issued in RUN, outside reset, and when the control unit is not stalling
  assign run_en = reset && (state_q == RUN) && !hold;

  rr_arbiter #(
    .NREQ  (NREQ),
    .PTR_W (PTR_W)
  ) u_arb (
    .clk       (clk),
    .reset     (reset),
    .enable    (run_en),
    .req       (req),
    .gnt       (gnt),
    .gnt_idx   (gnt_idx),
    .gnt_valid (gnt_valid)
  );

`ifdef REGFILE_CLEAR_EN
  localparam logic [2:0] LAST_REG = 3'(NUM_REGS - 1);

  logic [2:0] cnt;
  logic       clear_done;

  // State register: every reset restarts the clear sweep
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= CLEAR;
    end else begin
      state_q <= state_d;
    end
  end

  // Leave CLEAR one cycle after R7's write has been loaded, so busy covers that write
  always_comb begin
    state_d = state_q;
    if (state_q == CLEAR && clear_done) begin
      state_d = RUN;
    end
  end

  // Sweep counter walks R0..R7, then flags completion
  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt        <= '0;
      clear_done <= 1'b0;
    end else if (state_q == CLEAR && !clear_done) begin
      cnt <= cnt + 3'd1;
      if (cnt == LAST_REG) begin
        clear_done <= 1'b1;
      end
    end
  end

  assign busy     = (state_q == CLEAR);
  assign sweep_wr = (state_q == CLEAR) && !clear_done;
  assign sweep_dr = ADDR_W'(cnt);
`else
  // State register: without the sweep the scheduler lives in RUN
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // Only one reachable state in this build
  always_comb begin
    state_d = RUN;
  end

  assign busy     = 1'b0;
  assign sweep_wr = 1'b0;
  assign sweep_dr = '0;
`endif

  // Registered write port: sweep writes zeros, a grant loads the winner's
  // request, otherwise ld_reg drops and the address/data hold
  always_ff @(posedge clk) begin
    if (!reset) begin
      ld_reg  <= 1'b0;
      wr_dr   <= '0;
      wr_data <= '0;
    end else if (sweep_wr) begin
      ld_reg  <= 1'b1;
      wr_dr   <= sweep_dr;
      wr_data <= '0;
    end else if (gnt_valid) begin
      ld_reg  <= 1'b1;
      wr_dr   <= req_dr[gnt_idx*ADDR_W +: ADDR_W];
      wr_data <= req_data[gnt_idx*WORD_W +: WORD_W];
    end else begin
      ld_reg  <= 1'b0;
    end
  end

endmodule
